dsram_arbiter: RTL and testbench
================================

# dsram_arbiter

Two-requester arbiter for the single-port data SRAM. Shares the SRAM between the CPU memory-access stage (loads, stores, two-cycle misaligned-store pairs) and an external DMA/debug master. CPU has priority; a starvation counter guarantees DMA progress. Read data is routed back to the requester that issued the read.

## Interface
Parameters:
- `AW`, 32, byte address width.
- `STARVE_MAX`, 8, consecutive denied DMA cycles before DMA is forced through (1..255).

Ports:
- `clk`  in  1  core clock; all logic on rising edge.
- `cpurst_n`  in  1  reset, synchronous, active-low.
- `cpu_cs`  in  1  CPU access request this cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_ben`  in  4  write byte enables.
- `cpu_addr`  in  AW  byte address; SRAM uses word address `[AW-1:2]`.
- `cpu_wdata`  in  32  write data, already lane-aligned.
- `cpu_lock`  in  1  marks the first half of a misaligned store; the next cycle must also go to CPU.
- `cpu_stall`  out  1  CPU access not performed this cycle; CPU holds its request.
- `cpu_rdata`  out  32  read data.
- `cpu_rvalid`  out  1  `cpu_rdata` valid; asserted one cycle after a granted CPU read.
- `dma_req`  in  1  DMA request; held with its fields stable until granted.
- `dma_we`, `dma_ben[3:0]`, `dma_addr[AW-1:0]`, `dma_wdata[31:0]`  in  DMA access fields, same meaning as the CPU fields.
- `dma_gnt`  out  1  DMA access performed this cycle.
- `dma_rdata`  out  32  read data.
- `dma_rvalid`  out  1  asserted one cycle after a granted DMA read.
- `sram_cs`, `sram_we`, `sram_ben[3:0]`, `sram_addr[AW-3:0]`, `sram_wdata[31:0]`  out  SRAM port.
- `sram_rdata`  in  32  SRAM read data, valid the cycle after a read.

## Operation
- Grant is combinational, decided each cycle:
  - If `cpu_cs` and not `force_dma`: CPU is granted. `cpu_stall` = 0. `dma_gnt` = 0.
  - Else if `dma_req`: DMA is granted. `dma_gnt` = 1. `cpu_stall` = `cpu_cs`.
  - Else: no grant. `sram_cs` = 0.
- The SRAM mux drives the winner's fields. With no grant, `sram_we` = 0 and `sram_ben` = 0.
- `force_dma` = `dma_req` & (`starve_cnt` == `STARVE_MAX`) & ~`lock_q`.
- `lock_q` register: next value = `cpu_lock` & CPU granted. While `lock_q` = 1, DMA is never granted. The second half of a misaligned store is therefore never split from its first half.
- `starve_cnt` (8 bit):
  - Increments when `dma_req` & ~`dma_gnt`, saturating at `STARVE_MAX`.
  - Clears to 0 on `dma_gnt` or when `dma_req` = 0.
- `rd_owner` register (2 bit: NONE / CPU / DMA): set to the granted requester on a granted read, else NONE.
- Read return:
  - `cpu_rvalid` = (`rd_owner` == CPU). `dma_rvalid` = (`rd_owner` == DMA).
  - Both `*_rdata` outputs are wired to `sram_rdata`.

## Timing
- Reset (`cpurst_n` = 0 at a clock edge): `starve_cnt` = 0, `lock_q` = 0, `rd_owner` = NONE. Hence `cpu_rvalid` = 0 and `dma_rvalid` = 0.
- During reset all requests are ignored: `sram_cs` = 0, `dma_gnt` = 0, `cpu_stall` = 0.
- Grant latency is 0 cycles: grant happens in the request cycle.
- Read-data latency is exactly 1 cycle after the grant cycle. Back-to-back reads are supported, one per cycle.
- Reset asserted while a read is in flight: the return is dropped and `rvalid` is 0.
- CPU and DMA request in the same cycle, count below `STARVE_MAX`: CPU wins.
- With `STARVE_MAX` = N and a continuous CPU stream, DMA is granted in the (N+1)th cycle of its request. Exception: if that cycle has `lock_q` = 1, the grant is delayed by exactly one cycle.
- `cpu_lock` asserted in the cycle DMA is forced: CPU is stalled, so `lock_q` stays 0. CPU re-presents the pair later.
- No combinational path from `sram_rdata` to any grant signal.

## Structure
- Shared package `mem_pkg`: owner encoding (`OWN_NONE` = 0, `OWN_CPU` = 1, `OWN_DMA` = 2) and the byte-enable width constant, shared with the memory-access stage.
- One sub-module, `starve_counter`: parameterised saturating counter with `inc`, `clr` and `at_max` signals.
- The mux and `rd_owner` logic stay in the top module.

## Test plan
- Isolated CPU read, address 0x40: `sram_cs` = 1, `sram_addr` = 0x10 in cycle 0. With `sram_rdata` = 0xDEADBEEF in cycle 1 → `cpu_rvalid` = 1, `cpu_rdata` = 0xDEADBEEF, `dma_rvalid` = 0.
- DMA write, address 0x100, data 0x12345678, `ben` = 0xF, no CPU traffic → `dma_gnt` = 1 in the same cycle, `sram_we` = 1, `sram_addr` = 0x40.
- Continuous CPU traffic, DMA read held, `STARVE_MAX` = 8 → `dma_gnt` = 1 and `cpu_stall` = 1 in the 9th cycle. `dma_rvalid` = 1 in the 10th. `starve_cnt` returns to 0.
- Starvation limit reached while `lock_q` = 1 (misaligned SW at 0x...1) → both halves go to CPU. `dma_gnt` follows one cycle later.
- Interleaved reads CPU, DMA, CPU on consecutive cycles → `rvalid` toggles CPU, DMA, CPU with matching data and no misrouting.
- Reset pulsed the cycle after a DMA read grant → `dma_rvalid` stays 0 and `starve_cnt` = 0. The next cycle behaves as from power-up.

Source files
------------

// File: rtl/mem_pkg.sv
// Definitions shared between the data-SRAM arbiter and the memory-access stage:
// read-owner encoding and bus widths.
package mem_pkg;
  localparam int BEN_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;
endpackage

// File: rtl/dsram_arbiter_if.sv
// Bundle of the CPU, DMA and SRAM-side signals around the data-SRAM arbiter.
// The slave modport is the arbiter. The master modport is everything around it.
interface dsram_arbiter_if #(
  parameter int AW = 32
);
  import mem_pkg::*;

  logic              cpu_cs;
  logic              cpu_we;
  logic [BEN_W-1:0]  cpu_ben;
  logic [AW-1:0]     cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_lock;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [BEN_W-1:0]  dma_ben;
  logic [AW-1:0]     dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              sram_cs;
  logic              sram_we;
  logic [BEN_W-1:0]  sram_ben;
  logic [AW-3:0]     sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  cpu_cs, cpu_we, cpu_ben, cpu_addr, cpu_wdata, cpu_lock,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_ben, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output sram_cs, sram_we, sram_ben, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output cpu_cs, cpu_we, cpu_ben, cpu_addr, cpu_wdata, cpu_lock,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_ben, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  sram_cs, sram_we, sram_ben, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/dsram_arbiter_starve_counter.sv
// Saturating counter of consecutive denied DMA cycles.
// The at_max output depends only on the register, so it opens no combinational loop through the grant.
module starve_counter #(
  parameter int W   = 8,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic         at_max,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  // NOTE: state is updated with non-blocking assignments only. Reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_V);
endmodule

// File: rtl/dsram_arbiter.sv
// Shares the single-port data SRAM between the CPU and a DMA/debug master.
// The CPU has priority. Starved DMA is forced through, except in the second half of a locked misaligned store.
module dsram_arbiter
  import mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 8
) (
  input logic              clk,
  input logic              cpurst_n,
  dsram_arbiter_if.slave   bus
);
  logic       cpu_gnt;
  logic       dma_gnt;
  logic       force_dma;
  logic       lock_q;
  logic       at_max;
  logic       starve_inc;
  logic       starve_clr;
  logic [7:0] starve_cnt;
  owner_e     rd_owner;
  logic       unused_addr_lsbs;

  starve_counter #(
    .W   (8),
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (cpurst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max),
    .cnt    (starve_cnt)
  );

  // Grant depends only on requests and registered state. It never depends on sram_rdata.
  assign force_dma  = bus.dma_req & at_max & ~lock_q;
  assign cpu_gnt    = cpurst_n & bus.cpu_cs & ~force_dma;
  assign dma_gnt    = cpurst_n & bus.dma_req & ~cpu_gnt & ~lock_q;
  assign starve_inc = bus.dma_req & ~dma_gnt;
  assign starve_clr = ~bus.dma_req | dma_gnt;

  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = cpurst_n & bus.cpu_cs & ~cpu_gnt;

  // NOTE: every output of this block gets a default first, so the block infers no latch.
  always_comb begin
    bus.sram_cs    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_ben   = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (cpu_gnt) begin
      bus.sram_cs    = 1'b1;
      bus.sram_we    = bus.cpu_we;
      bus.sram_ben   = bus.cpu_ben;
      bus.sram_addr  = bus.cpu_addr[AW-1:2];
      bus.sram_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      bus.sram_cs    = 1'b1;
      bus.sram_we    = bus.dma_we;
      bus.sram_ben   = bus.dma_ben;
      bus.sram_addr  = bus.dma_addr[AW-1:2];
      bus.sram_wdata = bus.dma_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      lock_q   <= 1'b0;
      rd_owner <= OWN_NONE;
    end else begin
      lock_q <= bus.cpu_lock & cpu_gnt;
      if (cpu_gnt && !bus.cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (dma_gnt && !bus.dma_we) begin
        rd_owner <= OWN_DMA;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  // If reset arrives during the return cycle, the read is dropped.
  assign bus.cpu_rvalid = cpurst_n & (rd_owner == OWN_CPU);
  assign bus.dma_rvalid = cpurst_n & (rd_owner == OWN_DMA);
  assign bus.cpu_rdata  = bus.sram_rdata;
  assign bus.dma_rdata  = bus.sram_rdata;

  // The SRAM is word-addressed, so the byte-lane bits of each address are not needed.
  assign unused_addr_lsbs = ^{bus.cpu_addr[1:0], bus.dma_addr[1:0]};
endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter. A cycle-level model of the arbitration rules is compared
// against the DUT on every cycle. Literal expectations at key cycles also pin the model.
module tb_dsram_arbiter;
  import mem_pkg::*;

  localparam int AW   = 32;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic cpurst_n;
  always #5 clk = ~clk;

  dsram_arbiter_if #(.AW(AW)) bus ();

  dsram_arbiter #(
    .AW         (AW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk      (clk),
    .cpurst_n (cpurst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Model state: cycles DMA has waited, whether the CPU was granted with lock in the previous
  // cycle, and who receives the read data this cycle (0 none, 1 cpu, 2 dma).
  int waited    = 0;
  bit lock_prev = 1'b0;
  int pend      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void predict(output bit g_cpu, output bit g_dma);
    bit forced;
    forced = bus.dma_req && (waited >= SMAX) && !lock_prev;
    g_cpu  = cpurst_n && bus.cpu_cs && !forced;
    g_dma  = cpurst_n && bus.dma_req && !g_cpu && !lock_prev;
  endfunction

  always @(posedge clk) begin
    bit gc, gd;
    predict(gc, gd);
    if (!cpurst_n) begin
      waited    = 0;
      lock_prev = 1'b0;
      pend      = 0;
    end else begin
      waited    = (bus.dma_req && !gd) ? waited + 1 : 0;
      lock_prev = bus.cpu_lock && gc;
      pend      = (gc && !bus.cpu_we) ? 1 : (gd && !bus.dma_we) ? 2 : 0;
    end
  end

  always @(negedge clk) begin
    bit gc, gd;
    if (model_on) begin
      predict(gc, gd);
      check("m_dma_gnt", 64'(bus.dma_gnt), 64'(gd));
      check("m_cpu_stall", 64'(bus.cpu_stall), 64'(cpurst_n && bus.cpu_cs && !gc));
      check("m_sram_cs", 64'(bus.sram_cs), 64'(gc || gd));
      if (gc) begin
        check("m_we_cpu", 64'(bus.sram_we), 64'(bus.cpu_we));
        check("m_ben_cpu", 64'(bus.sram_ben), 64'(bus.cpu_ben));
        check("m_addr_cpu", 64'(bus.sram_addr), 64'(bus.cpu_addr) / 4);
        check("m_wdata_cpu", 64'(bus.sram_wdata), 64'(bus.cpu_wdata));
      end else if (gd) begin
        check("m_we_dma", 64'(bus.sram_we), 64'(bus.dma_we));
        check("m_ben_dma", 64'(bus.sram_ben), 64'(bus.dma_ben));
        check("m_addr_dma", 64'(bus.sram_addr), 64'(bus.dma_addr) / 4);
        check("m_wdata_dma", 64'(bus.sram_wdata), 64'(bus.dma_wdata));
      end else begin
        check("m_we_idle", 64'(bus.sram_we), 64'(0));
        check("m_ben_idle", 64'(bus.sram_ben), 64'(0));
      end
      check("m_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(cpurst_n && pend == 1));
      check("m_dma_rvalid", 64'(bus.dma_rvalid), 64'(cpurst_n && pend == 2));
      if (cpurst_n && pend == 1) check("m_cpu_rdata", 64'(bus.cpu_rdata), 64'(bus.sram_rdata));
      if (cpurst_n && pend == 2) check("m_dma_rdata", 64'(bus.dma_rdata), 64'(bus.sram_rdata));
    end
  end

  task automatic idle();
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_ben = '0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.cpu_lock = 1'b0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_ben = '0; bus.dma_addr = '0;
    bus.dma_wdata = '0;
    bus.sram_rdata = '0;
  endtask

  task automatic cpu_drive(input bit we, input logic [3:0] ben, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit lock);
    bus.cpu_cs = 1'b1; bus.cpu_we = we; bus.cpu_ben = ben; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_lock = lock;
  endtask

  task automatic dma_drive(input bit we, input logic [3:0] ben, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_ben = ben; bus.dma_addr = addr;
    bus.dma_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cpurst_n = 1'b0;
    idle();
    cpu_drive(1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
    dma_drive(1'b0, 4'hF, 32'h80, 32'h0);
    tick();
    model_on = 1'b1;

    // Requests are ignored while reset is held.
    neg();
    check("rst_sram_cs", 64'(bus.sram_cs), 64'(0));
    check("rst_dma_gnt", 64'(bus.dma_gnt), 64'(0));
    check("rst_cpu_stall", 64'(bus.cpu_stall), 64'(0));
    check("rst_rvalid", 64'({bus.cpu_rvalid, bus.dma_rvalid}), 64'(0));
    tick();
    cpurst_n = 1'b1;
    idle();

    // Isolated CPU read at 0x40.
    cpu_drive(1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
    neg();
    check("t1_sram_cs", 64'(bus.sram_cs), 64'(1));
    check("t1_sram_addr", 64'(bus.sram_addr), 64'h10);
    tick();
    idle();
    bus.sram_rdata = 32'hDEADBEEF;
    neg();
    check("t1_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(1));
    check("t1_cpu_rdata", 64'(bus.cpu_rdata), 64'hDEADBEEF);
    check("t1_dma_rvalid", 64'(bus.dma_rvalid), 64'(0));
    tick();

    // DMA write with no CPU traffic.
    idle();
    dma_drive(1'b1, 4'hF, 32'h100, 32'h12345678);
    neg();
    check("t2_dma_gnt", 64'(bus.dma_gnt), 64'(1));
    check("t2_sram_we", 64'(bus.sram_we), 64'(1));
    check("t2_sram_addr", 64'(bus.sram_addr), 64'h40);
    check("t2_sram_wdata", 64'(bus.sram_wdata), 64'h12345678);
    tick();
    idle();

    // Continuous CPU stores while a DMA read is held. DMA is forced through in cycle 9.
    for (int c = 1; c <= 9; c++) begin
      cpu_drive(1'b1, 4'h3, 32'h1000 + 32'(4 * c), 32'(c), 1'b0);
      dma_drive(1'b0, 4'hF, 32'h200, 32'h0);
      neg();
      if (c < 9) begin
        check("t3_wait_gnt", 64'(bus.dma_gnt), 64'(0));
      end else begin
        check("t3_forced_gnt", 64'(bus.dma_gnt), 64'(1));
        check("t3_forced_stall", 64'(bus.cpu_stall), 64'(1));
      end
      tick();
    end
    bus.dma_req = 1'b0;
    bus.sram_rdata = 32'hA5A55A5A;
    neg();
    check("t3_dma_rvalid", 64'(bus.dma_rvalid), 64'(1));
    check("t3_dma_rdata", 64'(bus.dma_rdata), 64'hA5A55A5A);
    check("t3_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(0));
    check("t3_starve_cnt", 64'(dut.starve_cnt), 64'(0));
    tick();
    idle();

    // The limit is reached while the second half of a misaligned store is locked.
    for (int c = 1; c <= 13; c++) begin
      idle();
      case (c)
        8:       cpu_drive(1'b1, 4'hE, 32'h300, 32'h11223300, 1'b1);
        9:       cpu_drive(1'b1, 4'h1, 32'h304, 32'h00000044, 1'b0);
        10:      cpu_drive(1'b1, 4'hE, 32'h300, 32'h11223300, 1'b1);
        11:      cpu_drive(1'b1, 4'hE, 32'h300, 32'h11223300, 1'b1);
        12:      cpu_drive(1'b1, 4'h1, 32'h304, 32'h00000044, 1'b0);
        13:      ;
        default: cpu_drive(1'b1, 4'hF, 32'h2000 + 32'(4 * c), 32'(c), 1'b0);
      endcase
      if (c != 11) dma_drive(1'b1, 4'hF, 32'h400, 32'h0000CAFE);
      neg();
      if (c == 9) begin
        check("t4_locked_gnt", 64'(bus.dma_gnt), 64'(0));
        check("t4_locked_stall", 64'(bus.cpu_stall), 64'(0));
      end
      if (c == 10) begin
        check("t4_late_gnt", 64'(bus.dma_gnt), 64'(1));
        check("t4_late_stall", 64'(bus.cpu_stall), 64'(1));
      end
      if (c == 12) check("t4_relock_gnt", 64'(bus.dma_gnt), 64'(0));
      if (c == 13) check("t4_after_gnt", 64'(bus.dma_gnt), 64'(1));
      tick();
    end
    idle();

    // Interleaved reads: CPU, then DMA, then CPU.
    cpu_drive(1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    tick();
    idle();
    dma_drive(1'b0, 4'hF, 32'h20, 32'h0);
    bus.sram_rdata = 32'h11111111;
    neg();
    check("t5_a_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(1));
    check("t5_a_dma_rvalid", 64'(bus.dma_rvalid), 64'(0));
    check("t5_a_cpu_rdata", 64'(bus.cpu_rdata), 64'h11111111);
    tick();
    idle();
    cpu_drive(1'b0, 4'hF, 32'h30, 32'h0, 1'b0);
    bus.sram_rdata = 32'h22222222;
    neg();
    check("t5_b_dma_rvalid", 64'(bus.dma_rvalid), 64'(1));
    check("t5_b_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(0));
    check("t5_b_dma_rdata", 64'(bus.dma_rdata), 64'h22222222);
    tick();
    idle();
    bus.sram_rdata = 32'h33333333;
    neg();
    check("t5_c_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(1));
    check("t5_c_dma_rvalid", 64'(bus.dma_rvalid), 64'(0));
    tick();

    // Reset in the cycle after a DMA read grant drops the return.
    idle();
    dma_drive(1'b0, 4'hF, 32'h80, 32'h0);
    tick();
    cpurst_n = 1'b0;
    cpu_drive(1'b1, 4'hF, 32'h84, 32'h5, 1'b0);
    bus.sram_rdata = 32'h77777777;
    neg();
    check("t6_rst_dma_rvalid", 64'(bus.dma_rvalid), 64'(0));
    check("t6_rst_sram_cs", 64'(bus.sram_cs), 64'(0));
    tick();
    cpurst_n = 1'b1;
    idle();
    cpu_drive(1'b0, 4'hF, 32'h44, 32'h0, 1'b0);
    neg();
    check("t6_starve_cnt", 64'(dut.starve_cnt), 64'(0));
    check("t6_dma_rvalid", 64'(bus.dma_rvalid), 64'(0));
    check("t6_sram_addr", 64'(bus.sram_addr), 64'h11);
    tick();
    idle();
    bus.sram_rdata = 32'h99;
    neg();
    check("t6_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(1));
    tick();
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
